// File: rtl/ext_bus_pkg.sv
// Shared types for the external bus arbiter: region codes, FSM states, requester IDs.
// Region code and wait-count widths are also defined here.
package ext_bus_pkg;

    localparam int REGION_W = 4;
    localparam int WAIT_W   = 3;

    typedef enum logic [REGION_W-1:0] {
        RGN_RAM   = 4'd0,
        RGN_GFX   = 4'd1,
        RGN_AUDIO = 4'd2,
        RGN_SPART = 4'd3,
        RGN_PS2   = 4'd4,
        RGN_SW    = 4'd5
    } region_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_t;

endpackage

// File: rtl/ext_bus_region_decode.sv
// Region decode: maps a region code and direction to a wait-state count and a
// legality flag. Purely combinational.
module ext_bus_region_decode
    import ext_bus_pkg::*;
#(
    parameter int RAM_WAIT = 1,
    parameter int GFX_WAIT = 2,
    parameter int SW_WAIT  = 1
) (
    input  logic [REGION_W-1:0] i_region,
    input  logic                i_we,
    output logic [WAIT_W-1:0]   o_wait,
    output logic                o_legal
);

    always_comb begin
        o_wait  = '0;
        o_legal = 1'b0;
        case (i_region)
            RGN_RAM: begin
                o_wait  = WAIT_W'(RAM_WAIT);
                o_legal = 1'b1;
            end
            RGN_GFX: begin
                o_wait  = WAIT_W'(GFX_WAIT);
                o_legal = 1'b1;
            end
            // audio is write-only; SPART, PS2 and switch are read-only
            RGN_AUDIO: o_legal = i_we;
            RGN_SPART: o_legal = ~i_we;
            RGN_PS2:   o_legal = ~i_we;
            RGN_SW: begin
                o_wait  = WAIT_W'(SW_WAIT);
                o_legal = ~i_we;
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ext_bus_arbiter.sv
// Two-requester arbiter for the external memory-mapped bus: alternating grant,
// per-region wait states, read capture and a one-cycle ack/err per access.
//
//   state  | meaning
//   IDLE   | sample requests, pick owner, latch access, decode region
//   STROBE | drive bus_read/bus_write for wait+1 cycles, capture read data at the end
//   DONE   | ack (registered on entry) visible to owner; owner recorded as last_grant
//   ERR    | illegal access: err ack visible, no strobe; owner recorded as last_grant
module ext_bus_arbiter
    import ext_bus_pkg::*;
#(
    parameter int RAM_WAIT = 1,
    parameter int GFX_WAIT = 2,
    parameter int SW_WAIT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic [15:0] dma_rdata,
    output logic        dma_ack,
    output logic        dma_err,
    output logic [3:0]  bus_addr,
    output logic [15:0] bus_wdata,
    output logic        bus_read,
    output logic        bus_write,
    input  logic [15:0] bus_rdata,
    output logic        grant
);

    state_t              r_state, w_state_nxt;
    logic [WAIT_W-1:0]   r_cnt, w_cnt_nxt;
    logic                r_last_grant;

    logic                r_grant, w_grant_nxt;
    logic [3:0]          r_bus_addr, w_bus_addr_nxt;
    logic [15:0]         r_bus_wdata, w_bus_wdata_nxt;
    logic                r_bus_read, w_bus_read_nxt;
    logic                r_bus_write, w_bus_write_nxt;
    logic [15:0]         r_cpu_rdata, w_cpu_rdata_nxt;
    logic                r_cpu_ack, w_cpu_ack_nxt;
    logic                r_cpu_err, w_cpu_err_nxt;
    logic [15:0]         r_dma_rdata, w_dma_rdata_nxt;
    logic                r_dma_ack, w_dma_ack_nxt;
    logic                r_dma_err, w_dma_err_nxt;

    logic                w_any, w_sel, w_req_we, w_legal;
    logic [15:0]         w_req_addr, w_req_wdata;
    logic [WAIT_W-1:0]   w_wait;
    logic                w_unused_addr;

    // On a tie the requester that did not own the previous access wins.
    assign w_any       = cpu_req | dma_req;
    assign w_sel       = dma_req & (~cpu_req | ~r_last_grant);
    assign w_req_we    = w_sel ? dma_we    : cpu_we;
    assign w_req_addr  = w_sel ? dma_addr  : cpu_addr;
    assign w_req_wdata = w_sel ? dma_wdata : cpu_wdata;
    assign w_unused_addr = ^w_req_addr[11:0];

    ext_bus_region_decode #(
        .RAM_WAIT (RAM_WAIT),
        .GFX_WAIT (GFX_WAIT),
        .SW_WAIT  (SW_WAIT)
    ) u_decode (
        .i_region (w_req_addr[15:12]),
        .i_we     (w_req_we),
        .o_wait   (w_wait),
        .o_legal  (w_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last_grant <= REQ_DMA;
            r_grant      <= REQ_CPU;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_bus_read   <= 1'b0;
            r_bus_write  <= 1'b0;
            r_cpu_rdata  <= '0;
            r_cpu_ack    <= 1'b0;
            r_cpu_err    <= 1'b0;
            r_dma_rdata  <= '0;
            r_dma_ack    <= 1'b0;
            r_dma_err    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            if (r_state == DONE || r_state == ERR)
                r_last_grant <= r_grant;
            r_grant     <= w_grant_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_bus_read  <= w_bus_read_nxt;
            r_bus_write <= w_bus_write_nxt;
            r_cpu_rdata <= w_cpu_rdata_nxt;
            r_cpu_ack   <= w_cpu_ack_nxt;
            r_cpu_err   <= w_cpu_err_nxt;
            r_dma_rdata <= w_dma_rdata_nxt;
            r_dma_ack   <= w_dma_ack_nxt;
            r_dma_err   <= w_dma_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = w_legal ? STROBE : ERR;
                    w_cnt_nxt   = w_wait;
                end
            end
            STROBE: begin
                if (r_cnt == '0)
                    w_state_nxt = DONE;
                else
                    w_cnt_nxt = r_cnt - 1'b1;
            end
            DONE:    w_state_nxt = IDLE;
            ERR:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output registers are loaded with the value for the state being entered.
    always_comb begin
        w_grant_nxt     = r_grant;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wdata_nxt = r_bus_wdata;
        w_bus_read_nxt  = 1'b0;
        w_bus_write_nxt = 1'b0;
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_cpu_ack_nxt   = 1'b0;
        w_cpu_err_nxt   = 1'b0;
        w_dma_rdata_nxt = r_dma_rdata;
        w_dma_ack_nxt   = 1'b0;
        w_dma_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_nxt = w_sel;
                    if (w_legal) begin
                        w_bus_addr_nxt  = w_req_addr[15:12];
                        w_bus_wdata_nxt = w_req_wdata;
                        w_bus_read_nxt  = ~w_req_we;
                        w_bus_write_nxt = w_req_we;
                    end else if (w_sel == REQ_DMA) begin
                        w_dma_ack_nxt   = 1'b1;
                        w_dma_err_nxt   = 1'b1;
                        w_dma_rdata_nxt = '0;
                    end else begin
                        w_cpu_ack_nxt   = 1'b1;
                        w_cpu_err_nxt   = 1'b1;
                        w_cpu_rdata_nxt = '0;
                    end
                end
            end
            STROBE: begin
                if (r_cnt != '0) begin
                    w_bus_read_nxt  = r_bus_read;
                    w_bus_write_nxt = r_bus_write;
                end else if (r_grant == REQ_DMA) begin
                    w_dma_ack_nxt = 1'b1;
                    if (r_bus_read)
                        w_dma_rdata_nxt = bus_rdata;
                end else begin
                    w_cpu_ack_nxt = 1'b1;
                    if (r_bus_read)
                        w_cpu_rdata_nxt = bus_rdata;
                end
            end
            default: ;
        endcase
    end

    assign grant     = r_grant;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_read  = r_bus_read;
    assign bus_write = r_bus_write;
    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ack   = r_cpu_ack;
    assign cpu_err   = r_cpu_err;
    assign dma_rdata = r_dma_rdata;
    assign dma_ack   = r_dma_ack;
    assign dma_err   = r_dma_err;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Bench for ext_bus_arbiter: directed cases plus random traffic from both
// requesters, checked by per-requester scoreboards and a bus-burst monitor.
module tb_ext_bus_arbiter;

    localparam int RAM_WAIT = 1;
    localparam int GFX_WAIT = 2;
    localparam int SW_WAIT  = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
    logic        cpu_ack, cpu_err;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] dma_addr = '0, dma_wdata = '0, dma_rdata;
    logic        dma_ack, dma_err;
    logic [3:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_read, bus_write;
    logic [15:0] bus_rdata = '0;
    logic        grant;

    ext_bus_arbiter #(
        .RAM_WAIT (RAM_WAIT),
        .GFX_WAIT (GFX_WAIT),
        .SW_WAIT  (SW_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_ack   (dma_ack),
        .dma_err   (dma_err),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_read  (bus_read),
        .bus_write (bus_write),
        .bus_rdata (bus_rdata),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // ---------------- reference model ----------------
    function automatic int wait_of(input logic [3:0] rg);
        case (rg)
            4'd0:    return RAM_WAIT;
            4'd1:    return GFX_WAIT;
            4'd5:    return SW_WAIT;
            default: return 0;
        endcase
    endfunction

    function automatic bit legal_of(input logic [3:0] rg, input bit we);
        if (rg > 4'd5) return 1'b0;
        if (we && rg >= 4'd3) return 1'b0;
        if (!we && rg == 4'd2) return 1'b0;
        return 1'b1;
    endfunction

    typedef struct {
        bit          err;
        bit          chk_rd;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb_cpu[$];
    exp_t sb_dma[$];
    int   order[$];

    logic [15:0] pend_addr [2];
    bit          pend_we   [2];
    logic [15:0] pend_wdata[2];

    // Bus device model: read data settles one step per strobe cycle, so only the
    // value on the final strobe cycle equals tbl[region] + wait.
    logic [15:0] tbl [16];
    int          rd_idx = 0;
    always @(negedge clk) begin
        if (bus_read) begin
            bus_rdata <= tbl[bus_addr] + 16'(rd_idx);
            rd_idx    <= rd_idx + 1;
        end else begin
            bus_rdata <= 16'h0000;
            rd_idx    <= 0;
        end
    end

    // ---------------- monitor ----------------
    exp_t        m_e;
    int          run = 0;
    logic [3:0]  b_rg;
    logic        b_we;
    logic        b_g;

    always @(negedge clk) begin
        if (rst) begin
            run = 0;
        end else begin
            chk("strobe_exclusive", 32'(bus_read & bus_write), 0);
            chk("ack_exclusive", 32'(cpu_ack & dma_ack), 0);
            if (cpu_ack) begin
                if (sb_cpu.size() == 0) begin
                    chk("cpu_unexpected_ack", 1, 0);
                end else begin
                    m_e = sb_cpu.pop_front();
                    chk("cpu_err", 32'(cpu_err), 32'(m_e.err));
                    if (m_e.chk_rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_e.rdata));
                    chk("cpu_ack_grant", 32'(grant), 0);
                    order.push_back(0);
                end
            end
            if (dma_ack) begin
                if (sb_dma.size() == 0) begin
                    chk("dma_unexpected_ack", 1, 0);
                end else begin
                    m_e = sb_dma.pop_front();
                    chk("dma_err", 32'(dma_err), 32'(m_e.err));
                    if (m_e.chk_rd) chk("dma_rdata", 32'(dma_rdata), 32'(m_e.rdata));
                    chk("dma_ack_grant", 32'(grant), 1);
                    order.push_back(1);
                end
            end
            if (bus_read || bus_write) begin
                if (run == 0) begin
                    b_rg = bus_addr;
                    b_we = bus_write;
                    b_g  = grant;
                    chk("burst_region", 32'(bus_addr), 32'(pend_addr[b_g][15:12]));
                    chk("burst_dir", 32'(bus_write), 32'(pend_we[b_g]));
                    if (bus_write) chk("burst_wdata", 32'(bus_wdata), 32'(pend_wdata[b_g]));
                    chk("burst_legal", 32'(legal_of(bus_addr, bus_write)), 1);
                end else begin
                    chk("burst_addr_stable", 32'(bus_addr), 32'(b_rg));
                    chk("burst_dir_stable", 32'(bus_write), 32'(b_we));
                    if (b_we) chk("burst_wdata_stable", 32'(bus_wdata), 32'(pend_wdata[b_g]));
                end
                run++;
            end else if (run > 0) begin
                chk("burst_len", run, wait_of(b_rg) + 1);
                run = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a rising edge; returns just after a rising edge with req low.
    task automatic do_req(input int id, input logic [15:0] addr, input bit we,
                          input logic [15:0] wd, output int lat);
        exp_t e;
        bit   got;
        int   t0;
        logic ack_now;
        e.err    = !legal_of(addr[15:12], we);
        e.chk_rd = e.err || !we;
        e.rdata  = e.err ? 16'h0000 :
                   (we ? 16'h0000 : tbl[addr[15:12]] + 16'(wait_of(addr[15:12])));
        pend_addr[id]  = addr;
        pend_we[id]    = we;
        pend_wdata[id] = wd;
        if (id == 0) begin
            sb_cpu.push_back(e);
            cpu_addr = addr; cpu_we = we; cpu_wdata = wd; cpu_req = 1'b1;
        end else begin
            sb_dma.push_back(e);
            dma_addr = addr; dma_we = we; dma_wdata = wd; dma_req = 1'b1;
        end
        t0  = cyc;
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            ack_now = (id == 0) ? cpu_ack : dma_ack;
            if (ack_now) begin
                got = 1'b1;
                lat = cyc - t0;
            end
        end
        if (!got) chk("ack_timeout", 0, 1);
        @(posedge clk); #1;
        if (id == 0) cpu_req = 1'b0;
        else         dma_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        for (int i = 0; i < 16; i++) tbl[i] = 16'h1100 * 16'(i) + 16'h0025;
        tbl[0] = 16'hBEEE;
        pend_addr[0] = '0; pend_addr[1] = '0;
        pend_we[0] = 1'b0; pend_we[1] = 1'b0;
        pend_wdata[0] = '0; pend_wdata[1] = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", 32'({bus_read, bus_write}), 0);
        chk("rst_acks_errs", 32'({cpu_ack, cpu_err, dma_ack, dma_err}), 0);
        chk("rst_rdata", 32'({cpu_rdata, dma_rdata}), 0);
        chk("rst_bus_addr_wdata", 32'({bus_addr, bus_wdata}), 0);
        chk("rst_grant", 32'(grant), 0);
        rst = 1'b0;

        // both requesters held continuously: strict alternation, CPU first after reset
        order.delete();
        fork
            begin
                int lc;
                for (int k = 0; k < 3; k++) do_req(0, 16'h0010 + 16'(k), 1'b0, 16'h0, lc);
            end
            begin
                int ld;
                for (int k = 0; k < 3; k++) do_req(1, 16'h0020 + 16'(k), 1'b0, 16'h0, ld);
            end
        join
        chk("alt_count", order.size(), 6);
        for (int k = 0; k < order.size(); k++) chk("alt_order", order[k], k % 2);

        // CPU RAM read
        do_req(0, 16'h0010, 1'b0, 16'h0, lat);
        chk("cpu_ram_read_latency", lat, 3);
        chk("cpu_ram_read_data", 32'(cpu_rdata), 32'hBEEF);

        // DMA graphics write
        do_req(1, 16'h1004, 1'b1, 16'h1234, lat);
        chk("dma_gfx_write_latency", lat, 4);
        chk("dma_gfx_write_grant", 32'(grant), 1);
        chk("cpu_rdata_hold", 32'(cpu_rdata), 32'hBEEF);

        // illegal accesses
        do_req(0, 16'h3000, 1'b1, 16'hAAAA, lat);
        chk("cpu_spart_write_latency", lat, 1);
        chk("cpu_spart_write_rdata", 32'(cpu_rdata), 0);
        do_req(1, 16'h7000, 1'b0, 16'h0, lat);
        chk("dma_rgn7_latency", lat, 1);
        do_req(1, 16'h2000, 1'b0, 16'h0, lat);
        chk("dma_audio_read_latency", lat, 1);
        do_req(0, 16'h5008, 1'b0, 16'h0, lat);
        chk("cpu_switch_read_latency", lat, 2 + SW_WAIT);

        // reset during the second strobe cycle of a graphics read
        pend_addr[0] = 16'h1000; pend_we[0] = 1'b0;
        cpu_addr = 16'h1000; cpu_we = 1'b0; cpu_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst_strobe_active", 32'(bus_read), 1);
        rst = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("midrst_strobes_off", 32'({bus_read, bus_write}), 0);
        chk("midrst_no_ack", 32'({cpu_ack, cpu_err}), 0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("midrst_quiet", 32'({cpu_ack, dma_ack, bus_read, bus_write}), 0);
        end
        @(posedge clk); #1;
        do_req(0, 16'h0040, 1'b0, 16'h0, lat);
        chk("post_rst_read_latency", lat, 3);

        // random traffic from both requesters
        fork
            begin
                int lr;
                for (int k = 0; k < 40; k++) begin
                    do_req(0, {4'($urandom_range(0, 7)), 12'($urandom)}, 1'($urandom_range(0, 1)),
                           16'($urandom), lr);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
            end
            begin
                int lr;
                for (int k = 0; k < 40; k++) begin
                    do_req(1, {4'($urandom_range(0, 7)), 12'($urandom)}, 1'($urandom_range(0, 1)),
                           16'($urandom), lr);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
            end
        join
        repeat (4) @(posedge clk);
        chk("sb_cpu_drained", sb_cpu.size(), 0);
        chk("sb_dma_drained", sb_dma.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
